hdmi_packet_arbiter: RTL and testbench
======================================

# hdmi_packet_arbiter

Schedules HDMI data-island packets between four packet sources: audio sample, audio clock regeneration, AVI InfoFrame and audio InfoFrame. It sits between the packet generators' ready/enable handshakes and the video timing sequencer's aux request/enable interface. It decides which source drives each 32-slot packet, how many packets an island carries, and when a null packet must be emitted. Its outputs steer the aux multiplexer feeding the three TMDS encoders.

## Interface
- MAX_PACKETS, 2 — packets granted per data island, 1..18.
- clk  in  1  pixel clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ready  in  4  per-source packet pending: bit0 audio sample (A), bit1 clock regen (B), bit2 AVI InfoFrame (C), bit3 audio InfoFrame (D). Held by a source until it is served.
- ae  in  1  aux enable from sequencer; high across every data-island packet period.
- slot  in  5  current packet slot 0..31 (valid while ae=1).
- packet_end  in  1  single-cycle pulse on slot 31 of each packet.
- aux_request  out  1  asks the sequencer to open or extend a data island.
- enable  out  4  one-hot (or zero) grant; the selected source drives header/sub bits.
- grant_id  out  2  encoded index of the current grant.
- null_packet  out  1  high while in an island with no source granted; the mux sends zeros.
- packet_count  out  5  packets completed in the current island.

## Operation
- States: IDLE, ARMED, ISLAND, TAIL.
- Arbitration (GRANT function) runs on `ready & ~served_mask`:
  - A always wins when present.
  - Among B..D, the selection is defined under Configuration.
- **IDLE**
  - aux_request=0, enable=0.
  - If |ready: latch grant, set enable=onehot(grant), aux_request=1, go to ARMED.
- **ARMED**
  - Hold grant.
  - ae rising: go to ISLAND; the packet starts with enable already valid at slot 0.
  - If ready[grant] drops before ae, re-arbitrate the same cycle. If no source remains, go to IDLE.
- **ISLAND**, on packet_end:
  - packet_count+1.
  - served_mask |= onehot(grant).
  - If packet_count+1 < MAX_PACKETS and a masked source is ready: regrant; the new enable is valid on the next cycle (slot 0 of the next packet). Stay in ISLAND.
  - Otherwise: enable=0, null_packet=1, aux_request=0, go to TAIL.
- **TAIL**
  - null_packet=1 while ae=1.
  - ae low: go to IDLE; clear packet_count and served_mask.
- **Abort**
  - ae falls in ISLAND without packet_end: clear enable, go to IDLE.
  - The aborted source is not added to served_mask, so it is re-requested.
- **Simultaneous events**
  - packet_end and ae-low in the same cycle: treat as completion, then go to IDLE.
  - A asserting ready during a packet does not preempt it; A wins at the next packet_end.
- **Arithmetic**
  - packet_count saturates at 31.
  - MAX_PACKETS=1 means every island carries exactly one granted packet.

## Timing
- Reset values (async assert, sync release): state=IDLE, enable=0, grant_id=0, aux_request=0, null_packet=0, packet_count=0, served_mask=0, rr_ptr=3.
- ready to aux_request and enable: 1 cycle.
- packet_end to next enable or null_packet: 1 cycle; valid at the following slot 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- enable is constant across slots 0..31 of a packet.

## Configuration
- HDMI_PKT_ARB_RR_EN defined:
  - B..D are round-robin.
  - The search starts after rr_ptr (last granted of B..D).
  - rr_ptr updates on each B..D grant.
- Undefined:
  - Fixed priority A>B>C>D.
  - rr_ptr logic is removed.

## Test plan
- **Single source.** Reset, then ready=4'b0100. Required: aux_request=1 and enable=4'b0100 one cycle later. After ae and packet_end: null_packet=1, packet_count=1; after ae low: back to IDLE.
- **Two packets, MAX_PACKETS=2.** ready=4'b0011. Required: A granted first; B granted the cycle after packet_end; after the second packet_end: TAIL, packet_count=2.
- **Round robin (RR_EN).** B, C, D held ready across three single-packet islands. Required grants B, C, D. Without the macro: B, B, B.
- **Abort.** Drop ae at slot 17 of a C packet. Required: enable=0 next cycle, IDLE, C re-requested with aux_request=1 next cycle.
- **Async reset mid-island.** Pull reset_n low during slot 10. Required: all outputs 0 immediately; no grant until the first clock after reset_n rises.
- **Late A.** Raise A's ready during a D packet, MAX_PACKETS=2. Required: D completes; A granted at the next slot 0.

Source files
------------

// File: rtl/hdmi_packet_arbiter.sv
// ---------------------------------------------------------------------------
// hdmi_packet_arbiter
//
// Picks which of four HDMI data-island packet sources drives each 32-slot
// packet, decides how many packets an island carries (MAX_PACKETS) and
// flags null packets for the tail of an island.
//
// Optional feature macro: HDMI_PKT_ARB_RR_EN
//   defined   : audio sample (A) always wins, B..D share round-robin,
//               with the search starting after the last granted of B..D.
//   undefined : fixed priority A > B > C > D.
//
// Ports
//   clk          pixel clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   ready[3:0]   per-source pending (A, B, C, D), held until served
//   ae           aux enable from the sequencer, high across island packets
//   slot[4:0]    packet slot 0..31, valid while ae=1
//   packet_end   one-cycle pulse on slot 31
//   aux_request  asks the sequencer to open or extend an island
//   enable[3:0]  one-hot grant (or zero) steering the aux mux
//   grant_id     encoded index of the most recent grant (held when idle)
//   null_packet  high in the island tail, the mux sends zeros
//   packet_count packets completed in the current island (saturates at 31)
// ---------------------------------------------------------------------------
module hdmi_packet_arbiter #(
    parameter int MAX_PACKETS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] ready,
    input  logic       ae,
    input  logic [4:0] slot,
    input  logic       packet_end,
    output logic       aux_request,
    output logic [3:0] enable,
    output logic [1:0] grant_id,
    output logic       null_packet,
    output logic [4:0] packet_count
);

    typedef enum logic [1:0] {IDLE, ARMED, ISLAND, TAIL} state_t;

    state_t     r_state;
    logic [3:0] r_enable;
    logic [3:0] r_served;
    logic [1:0] r_grant;
    logic       r_aux;
    logic       r_null;
    logic [4:0] r_count;

    logic [3:0] w_avail;
    logic [3:0] w_served_next;
    logic [3:0] w_avail_end;
    logic [1:0] w_pick;
    logic [1:0] w_pick_end;
    logic [4:0] w_count_inc;
    logic       w_more;
    logic       w_start;
    logic       w_grant_vld;
    logic [1:0] w_grant_idx;

    function automatic logic [3:0] f_onehot(input logic [1:0] g);
        return 4'b0001 << g;
    endfunction

`ifdef HDMI_PKT_ARB_RR_EN
    logic [1:0] r_rr_ptr;

    // A first; otherwise walk B..D starting just after ptr, wrapping 3 -> 1.
    // Iterating k downwards lets the nearest candidate overwrite the rest.
    function automatic logic [1:0] f_pick(input logic [3:0] av, input logic [1:0] ptr);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = 2'd0;
        if (!av[0]) begin
            for (int k = 3; k >= 1; k--) begin
                idx = 2'(((int'(ptr) + 2 + k) % 3) + 1);
                if (av[idx]) sel = idx;
            end
        end
        return sel;
    endfunction

    assign w_pick     = f_pick(w_avail, r_rr_ptr);
    assign w_pick_end = f_pick(w_avail_end, r_rr_ptr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_rr_ptr <= 2'd3;
        else if (w_grant_vld && (w_grant_idx != 2'd0))
            r_rr_ptr <= w_grant_idx;
    end
`else
    // Fixed priority: lowest index wins.
    function automatic logic [1:0] f_pick(input logic [3:0] av);
        logic [1:0] sel;
        sel = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (av[2'(i)]) sel = 2'(i);
        return sel;
    endfunction

    assign w_pick     = f_pick(w_avail);
    assign w_pick_end = f_pick(w_avail_end);
`endif

    assign w_avail       = ready & ~r_served;
    // Mask as it will be once the current packet completes, so the
    // regrant at packet_end never reselects the source just served.
    assign w_served_next = r_served | f_onehot(r_grant);
    assign w_avail_end   = ready & ~w_served_next;
    assign w_count_inc   = (r_count == 5'd31) ? 5'd31 : r_count + 5'd1;
    assign w_more        = (({1'b0, r_count} + 6'd1) < 6'(MAX_PACKETS));
    // The sequencer opens each packet at slot 0 with ae already high.
    assign w_start       = ae && (slot == 5'd0);

    // Every new grant, whichever state produced it.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = w_pick;
        case (r_state)
            IDLE:    w_grant_vld = |w_avail;
            ARMED:   w_grant_vld = !w_start && !ready[r_grant] && (|w_avail);
            ISLAND: begin
                w_grant_idx = w_pick_end;
                w_grant_vld = packet_end && ae && w_more && (|w_avail_end);
            end
            default: w_grant_vld = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_enable <= 4'd0;
            r_served <= 4'd0;
            r_grant  <= 2'd0;
            r_aux    <= 1'b0;
            r_null   <= 1'b0;
            r_count  <= 5'd0;
        end else begin
            if (w_grant_vld) begin
                r_grant  <= w_grant_idx;
                r_enable <= f_onehot(w_grant_idx);
                r_aux    <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) r_state <= ARMED;
                end
                ARMED: begin
                    if (w_start) begin
                        r_state <= ISLAND;
                    end else if (!ready[r_grant] && !w_grant_vld) begin
                        // Granted source withdrew and nothing else is pending.
                        r_enable <= 4'd0;
                        r_aux    <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                ISLAND: begin
                    if (packet_end) begin
                        r_count  <= w_count_inc;
                        r_served <= w_served_next;
                        if (!ae) begin
                            // Completed and closed in the same cycle.
                            r_enable <= 4'd0;
                            r_aux    <= 1'b0;
                            r_count  <= 5'd0;
                            r_served <= 4'd0;
                            r_state  <= IDLE;
                        end else if (!w_grant_vld) begin
                            r_enable <= 4'd0;
                            r_aux    <= 1'b0;
                            r_null   <= 1'b1;
                            r_state  <= TAIL;
                        end
                    end else if (!ae) begin
                        // Abort: the source stays unserved and re-requests.
                        r_enable <= 4'd0;
                        r_aux    <= 1'b0;
                        r_count  <= 5'd0;
                        r_served <= 4'd0;
                        r_state  <= IDLE;
                    end
                end
                TAIL: begin
                    if (!ae) begin
                        r_null   <= 1'b0;
                        r_count  <= 5'd0;
                        r_served <= 4'd0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign aux_request  = r_aux;
    assign enable       = r_enable;
    assign grant_id     = r_grant;
    assign null_packet  = r_null;
    assign packet_count = r_count;

endmodule

// File: tb/tb_hdmi_packet_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for hdmi_packet_arbiter (MAX_PACKETS=2). A behavioural model tracks
// the island phase, the current source and the served set; a compare
// process checks every output against it each cycle, and the directed
// scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_hdmi_packet_arbiter;
    localparam int MAXP = 2;
    localparam int P_IDLE = 0, P_ARMED = 1, P_ISLAND = 2, P_TAIL = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] ready = 4'd0;
    logic       ae = 1'b0;
    logic [4:0] slot = 5'd0;
    logic       packet_end = 1'b0;
    logic       aux_request;
    logic [3:0] enable;
    logic [1:0] grant_id;
    logic       null_packet;
    logic [4:0] packet_count;

    always #5 clk = ~clk;

    hdmi_packet_arbiter #(.MAX_PACKETS(MAXP)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ready        (ready),
        .ae           (ae),
        .slot         (slot),
        .packet_end   (packet_end),
        .aux_request  (aux_request),
        .enable       (enable),
        .grant_id     (grant_id),
        .null_packet  (null_packet),
        .packet_count (packet_count)
    );

    int n_chk = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int      m_ph, m_cur, m_gid, m_cnt, m_last;
    bit [3:0] m_served;
    bit      m_ae_prev;

    function automatic int pick(input bit [3:0] av, input int last);
        if (av[0]) return 0;
`ifdef HDMI_PKT_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last - 1 + k) % 3 + 1;
            if (av[i]) return i;
        end
`else
        for (int i = 1; i <= 3; i++)
            if (av[i]) return i;
`endif
        return -1;
    endfunction

    task automatic m_grant(input bit [3:0] av);
        m_cur = pick(av, m_last);
        m_gid = m_cur;
        if (m_cur > 0) m_last = m_cur;
    endtask

    task automatic m_idle();
        m_ph = P_IDLE;
        m_cnt = 0;
        m_served = 4'd0;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_ph = P_IDLE; m_cur = 0; m_gid = 0; m_cnt = 0; m_last = 3;
            m_served = 4'd0; m_ae_prev = 1'b0;
        end else begin
            case (m_ph)
                P_IDLE:
                    if (ready != 4'd0) begin m_grant(ready); m_ph = P_ARMED; end
                P_ARMED:
                    if (ae && !m_ae_prev) m_ph = P_ISLAND;
                    else if (!ready[m_cur]) begin
                        if (ready != 4'd0) m_grant(ready);
                        else m_ph = P_IDLE;
                    end
                P_ISLAND:
                    if (packet_end) begin
                        m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
                        m_served[m_cur] = 1'b1;
                        if (!ae) m_idle();
                        else if (m_cnt < MAXP && (ready & ~m_served) != 4'd0) m_grant(ready & ~m_served);
                        else m_ph = P_TAIL;
                    end else if (!ae) m_idle();
                P_TAIL:
                    if (!ae) m_idle();
                default: m_idle();
            endcase
            m_ae_prev = ae;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [3:0] e_en;
        bit         live;
        @(negedge clk);
        if (cmp_on) begin
            live = (m_ph == P_ARMED) || (m_ph == P_ISLAND);
            e_en = live ? (4'b0001 << m_cur) : 4'd0;
            chk("model.aux_request", 32'(aux_request), 32'(live));
            chk("model.enable", 32'(enable), 32'(e_en));
            chk("model.grant_id", 32'(grant_id), 32'(m_gid));
            chk("model.null_packet", 32'(null_packet), 32'(m_ph == P_TAIL));
            chk("model.packet_count", 32'(packet_count), 32'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; ready = 4'd0; ae = 1'b0; slot = 5'd0; packet_end = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One packet: slots 0..31 on successive cycles. stop_at drops ae at that
    // slot (abort); end_low drops ae together with packet_end; raise_a sets
    // A's ready at that slot.
    task automatic send_packet(input int stop_at, input bit end_low, input int raise_a);
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            slot = 5'(s);
            if (s == stop_at) begin
                ae = 1'b0; packet_end = 1'b0;
                return;
            end
            if (s == raise_a) ready[0] = 1'b1;
            ae = 1'b1;
            packet_end = (s == 31);
            if (s == 31 && end_low) ae = 1'b0;
        end
    endtask

    task automatic close_island(input int tail_n);
        repeat (tail_n) begin
            @(negedge clk);
            packet_end = 1'b0; slot = 5'd0;
        end
        @(negedge clk);
        ae = 1'b0; packet_end = 1'b0; slot = 5'd0;
    endtask

    task automatic wait_aux(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = aux_request;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [1:0] exp_rr [3];
`ifdef HDMI_PKT_ARB_RR_EN
        exp_rr[0] = 2'd1; exp_rr[1] = 2'd2; exp_rr[2] = 2'd3;
`else
        exp_rr[0] = 2'd1; exp_rr[1] = 2'd1; exp_rr[2] = 2'd1;
`endif
        do_reset();
        #1;
        chk("rst.aux", 32'(aux_request), 32'd0);
        chk("rst.enable", 32'(enable), 32'd0);
        chk("rst.grant_id", 32'(grant_id), 32'd0);
        chk("rst.null", 32'(null_packet), 32'd0);
        chk("rst.count", 32'(packet_count), 32'd0);
        cmp_on = 1'b1;

        // Single source C
        @(negedge clk); ready = 4'b0100;
        tick();
        chk("t1.aux", 32'(aux_request), 32'd1);
        chk("t1.enable", 32'(enable), 32'h4);
        chk("t1.grant_id", 32'(grant_id), 32'd2);
        send_packet(-1, 1'b0, -1);
        tick();
        chk("t1.null", 32'(null_packet), 32'd1);
        chk("t1.count", 32'(packet_count), 32'd1);
        chk("t1.enable_off", 32'(enable), 32'd0);
        ready = 4'd0;
        close_island(3);
        tick();
        chk("t1.idle_null", 32'(null_packet), 32'd0);
        chk("t1.idle_count", 32'(packet_count), 32'd0);

        // Two packets: A then B
        @(negedge clk); ready = 4'b0011;
        tick();
        chk("t2.first", 32'(enable), 32'h1);
        send_packet(-1, 1'b0, -1);
        tick();
        chk("t2.second", 32'(enable), 32'h2);
        chk("t2.count1", 32'(packet_count), 32'd1);
        ready = 4'b0010;
        send_packet(-1, 1'b0, -1);
        tick();
        chk("t2.tail_null", 32'(null_packet), 32'd1);
        chk("t2.tail_count", 32'(packet_count), 32'd2);
        chk("t2.tail_aux", 32'(aux_request), 32'd0);
        ready = 4'd0;
        close_island(2);
        tick();

        // B, C, D held across three single-packet islands
        do_reset();
        @(negedge clk); ready = 4'b1110;
        for (int n = 0; n < 3; n++) begin
            wait_aux($sformatf("t3.aux%0d", n));
            chk($sformatf("t3.grant%0d", n), 32'(grant_id), 32'(exp_rr[n]));
            send_packet(-1, 1'b1, -1);
            close_island(0);
        end
        ready = 4'd0;
        tick(); tick();

        // Abort at slot 17 of a C packet
        do_reset();
        @(negedge clk); ready = 4'b0100;
        wait_aux("t4.aux");
        send_packet(17, 1'b0, -1);
        tick();
        chk("t4.abort_en", 32'(enable), 32'd0);
        chk("t4.abort_aux", 32'(aux_request), 32'd0);
        tick();
        chk("t4.rereq_aux", 32'(aux_request), 32'd1);
        chk("t4.rereq_en", 32'(enable), 32'h4);
        send_packet(-1, 1'b0, -1);
        tick();
        ready = 4'd0;
        close_island(1);
        tick();

        // Async reset in the middle of a D packet
        @(negedge clk); ready = 4'b1000;
        wait_aux("t5.aux");
        for (int s = 0; s <= 10; s++) begin
            @(negedge clk);
            ae = 1'b1; slot = 5'(s); packet_end = 1'b0;
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t5.rst_en", 32'(enable), 32'd0);
        chk("t5.rst_aux", 32'(aux_request), 32'd0);
        chk("t5.rst_gid", 32'(grant_id), 32'd0);
        ae = 1'b0; slot = 5'd0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("t5.hold_aux", 32'(aux_request), 32'd0);
        tick();
        chk("t5.regrant_aux", 32'(aux_request), 32'd1);
        chk("t5.regrant_en", 32'(enable), 32'h8);
        ready = 4'd0;
        tick(); tick();

        // A arrives during a D packet
        do_reset();
        @(negedge clk); ready = 4'b1000;
        wait_aux("t6.aux");
        send_packet(-1, 1'b0, 10);
        tick();
        chk("t6.a_gid", 32'(grant_id), 32'd0);
        chk("t6.a_en", 32'(enable), 32'h1);
        chk("t6.count1", 32'(packet_count), 32'd1);
        ready = 4'b0001;
        send_packet(-1, 1'b0, -1);
        tick();
        chk("t6.tail_null", 32'(null_packet), 32'd1);
        chk("t6.tail_count", 32'(packet_count), 32'd2);
        ready = 4'd0;
        close_island(1);
        tick();

        // Granted source withdraws before ae: re-arbitrate, then go idle
        @(negedge clk); ready = 4'b0100;
        tick();
        chk("t7.armed_en", 32'(enable), 32'h4);
        @(negedge clk); ready = 4'b0010;
        tick();
        chk("t7.rearb_en", 32'(enable), 32'h2);
        chk("t7.rearb_gid", 32'(grant_id), 32'd1);
        @(negedge clk); ready = 4'd0;
        tick();
        chk("t7.drop_aux", 32'(aux_request), 32'd0);
        chk("t7.drop_en", 32'(enable), 32'd0);

        @(negedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
